// File: rtl/reduction_offload_arbiter.sv
// Shares one reduction ALU between the narrow and wide offload ports: round-robin request
// arbitration with a 0-cycle request path, in-order tag FIFO steering each result home.
module reduction_offload_arbiter #(
  parameter int unsigned OpWidth        = 4,
  parameter int unsigned NarrowWidth    = 64,
  parameter int unsigned WideWidth      = 512,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [OpWidth-1:0]                    nar_req_op_i,
  input  logic [NarrowWidth-1:0]                nar_req_operand1_i,
  input  logic [NarrowWidth-1:0]                nar_req_operand2_i,
  input  logic                                  nar_req_valid_i,
  output logic                                  nar_req_ready_o,
  output logic [NarrowWidth-1:0]                nar_resp_result_o,
  output logic                                  nar_resp_valid_o,
  input  logic                                  nar_resp_ready_i,
  input  logic [OpWidth-1:0]                    wide_req_op_i,
  input  logic [WideWidth-1:0]                  wide_req_operand1_i,
  input  logic [WideWidth-1:0]                  wide_req_operand2_i,
  input  logic                                  wide_req_valid_i,
  output logic                                  wide_req_ready_o,
  output logic [WideWidth-1:0]                  wide_resp_result_o,
  output logic                                  wide_resp_valid_o,
  input  logic                                  wide_resp_ready_i,
  output logic [OpWidth-1:0]                    alu_req_op_o,
  output logic [WideWidth-1:0]                  alu_req_operand1_o,
  output logic [WideWidth-1:0]                  alu_req_operand2_o,
  output logic                                  alu_req_is_narrow_o,
  output logic                                  alu_req_valid_o,
  input  logic                                  alu_req_ready_i,
  input  logic [WideWidth-1:0]                  alu_resp_result_i,
  input  logic                                  alu_resp_valid_i,
  output logic                                  alu_resp_ready_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  err_unexpected_resp_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  logic                      rr_q, rr_d;  // 1 = wide preferred
  logic                      lock_q, lock_d;
  logic                      lock_wide_q, lock_wide_d;
  logic                      err_q, err_d;
  logic [MaxOutstanding-1:0] tag_q, tag_d;  // 1 = narrow origin
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]           cnt_q, cnt_d;

  logic full, empty, grant_wide, push, pop, head_narrow;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutstanding - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    full  = (cnt_q == CntW'(MaxOutstanding));
    empty = (cnt_q == '0);

    // A stalled request keeps its grant so the ALU sees stable operands.
    if (lock_q)    grant_wide = lock_wide_q;
    else if (rr_q) grant_wide = wide_req_valid_i;
    else           grant_wide = !nar_req_valid_i;

    alu_req_valid_o     = !rst_i && !full && (grant_wide ? wide_req_valid_i : nar_req_valid_i);
    alu_req_op_o        = grant_wide ? wide_req_op_i : nar_req_op_i;
    alu_req_operand1_o  = grant_wide ? wide_req_operand1_i : WideWidth'(nar_req_operand1_i);
    alu_req_operand2_o  = grant_wide ? wide_req_operand2_i : WideWidth'(nar_req_operand2_i);
    alu_req_is_narrow_o = !grant_wide;
    nar_req_ready_o     = !rst_i && !full && !grant_wide && alu_req_ready_i;
    wide_req_ready_o    = !rst_i && !full &&  grant_wide && alu_req_ready_i;
    push                = alu_req_valid_o && alu_req_ready_i;

    head_narrow        = tag_q[rd_ptr_q];
    nar_resp_result_o  = alu_resp_result_i[NarrowWidth-1:0];
    wide_resp_result_o = alu_resp_result_i;
    nar_resp_valid_o   = !rst_i && !empty &&  head_narrow && alu_resp_valid_i;
    wide_resp_valid_o  = !rst_i && !empty && !head_narrow && alu_resp_valid_i;
    // With nothing outstanding, responses are swallowed so a stray one cannot wedge the ALU.
    if (rst_i)      alu_resp_ready_o = 1'b0;
    else if (empty) alu_resp_ready_o = 1'b1;
    else            alu_resp_ready_o = head_narrow ? nar_resp_ready_i : wide_resp_ready_i;
    pop = alu_resp_valid_i && alu_resp_ready_o && !empty;

    rr_d        = rr_q;
    lock_d      = lock_q;
    lock_wide_d = lock_wide_q;
    if (push) begin
      rr_d   = !grant_wide;
      lock_d = 1'b0;
    end else if (alu_req_valid_o) begin
      lock_d      = 1'b1;
      lock_wide_d = grant_wide;
    end

    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      tag_d[wr_ptr_q] = !grant_wide;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;

    err_d = err_q || (alu_resp_valid_i && empty);

    outstanding_o         = cnt_q;
    err_unexpected_resp_o = err_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q        <= 1'b0;
      lock_q      <= 1'b0;
      lock_wide_q <= 1'b0;
      err_q       <= 1'b0;
      tag_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      lock_wide_q <= lock_wide_d;
      err_q       <= err_d;
      tag_q       <= tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_reduction_offload_arbiter.sv
// Randomized bench for reduction_offload_arbiter: requesters, an in-order ALU and
// response sinks are modelled here; a queue-based reference predicts every output.
module tb_reduction_offload_arbiter;
  localparam int OW = 4;
  localparam int NW = 64;
  localparam int WW = 512;
  localparam int MO = 4;
  localparam int CW = $clog2(MO + 1);
  localparam logic [WW-1:0] HI_MASK = {{((WW - NW) / 64){64'h5A5A5A5A5A5A5A5A}}, 64'h0};

  logic          clk_i, rst_i;
  logic [OW-1:0] nar_req_op_i, wide_req_op_i, alu_req_op_o;
  logic [NW-1:0] nar_req_operand1_i, nar_req_operand2_i, nar_resp_result_o;
  logic [WW-1:0] wide_req_operand1_i, wide_req_operand2_i, wide_resp_result_o;
  logic [WW-1:0] alu_req_operand1_o, alu_req_operand2_o, alu_resp_result_i;
  logic          nar_req_valid_i, nar_req_ready_o, nar_resp_valid_o, nar_resp_ready_i;
  logic          wide_req_valid_i, wide_req_ready_o, wide_resp_valid_o, wide_resp_ready_i;
  logic          alu_req_is_narrow_o, alu_req_valid_o, alu_req_ready_i;
  logic          alu_resp_valid_i, alu_resp_ready_o, err_unexpected_resp_o;
  logic [CW-1:0] outstanding_o;

  reduction_offload_arbiter #(
    .OpWidth(OW), .NarrowWidth(NW), .WideWidth(WW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .nar_req_op_i(nar_req_op_i), .nar_req_operand1_i(nar_req_operand1_i),
    .nar_req_operand2_i(nar_req_operand2_i), .nar_req_valid_i(nar_req_valid_i),
    .nar_req_ready_o(nar_req_ready_o), .nar_resp_result_o(nar_resp_result_o),
    .nar_resp_valid_o(nar_resp_valid_o), .nar_resp_ready_i(nar_resp_ready_i),
    .wide_req_op_i(wide_req_op_i), .wide_req_operand1_i(wide_req_operand1_i),
    .wide_req_operand2_i(wide_req_operand2_i), .wide_req_valid_i(wide_req_valid_i),
    .wide_req_ready_o(wide_req_ready_o), .wide_resp_result_o(wide_resp_result_o),
    .wide_resp_valid_o(wide_resp_valid_o), .wide_resp_ready_i(wide_resp_ready_i),
    .alu_req_op_o(alu_req_op_o), .alu_req_operand1_o(alu_req_operand1_o),
    .alu_req_operand2_o(alu_req_operand2_o), .alu_req_is_narrow_o(alu_req_is_narrow_o),
    .alu_req_valid_o(alu_req_valid_o), .alu_req_ready_i(alu_req_ready_i),
    .alu_resp_result_i(alu_resp_result_i), .alu_resp_valid_i(alu_resp_valid_i),
    .alu_resp_ready_o(alu_resp_ready_o), .outstanding_o(outstanding_o),
    .err_unexpected_resp_o(err_unexpected_resp_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Environment state
  bit            rst_req, hold_reqs, n_pend, w_pend, presenting;
  logic [OW-1:0] n_op, w_op;
  logic [NW-1:0] n_a, n_b;
  logic [WW-1:0] w_a, w_b;
  logic [WW-1:0] alu_q[$];
  int            p_req, p_arr, p_resp, p_prr;

  // Reference model state
  bit            m_rr_wide, m_lock, m_lock_wide, m_err;
  bit            m_tags[$];
  logic [WW-1:0] exp_n_q[$], exp_w_q[$];

  int n_vec, n_err;

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] rand_wide();
    logic [WW-1:0] r;
    for (int i = 0; i < WW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [NW-1:0] rand_nar();
    case ($urandom_range(3))
      0:       return '1;
      1:       return NW'(1);
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // ALU behaviour: sum plus opcode, upper lanes scrambled so truncation is visible.
  function automatic logic [WW-1:0] alu_fn(input logic [OW-1:0] op, input logic [WW-1:0] a,
                                           input logic [WW-1:0] b);
    return (a + b + WW'(op)) ^ HI_MASK;
  endfunction

  task automatic set_probs(input int req, input int arr, input int resp, input int prr);
    p_req = req; p_arr = arr; p_resp = resp; p_prr = prr;
  endtask

  task automatic drive();
    rst_i = rst_req;
    if (!n_pend && !hold_reqs && $urandom_range(99) < p_req) begin
      n_pend = 1'b1; n_op = OW'($urandom()); n_a = rand_nar(); n_b = rand_nar();
    end
    if (!w_pend && !hold_reqs && $urandom_range(99) < p_req) begin
      w_pend = 1'b1; w_op = OW'($urandom()); w_a = rand_wide(); w_b = rand_wide();
    end
    nar_req_valid_i    = n_pend;
    nar_req_op_i       = n_op;
    nar_req_operand1_i = n_a;
    nar_req_operand2_i = n_b;
    wide_req_valid_i    = w_pend;
    wide_req_op_i       = w_op;
    wide_req_operand1_i = w_a;
    wide_req_operand2_i = w_b;
    alu_req_ready_i = ($urandom_range(99) < p_arr);
    if (!presenting && alu_q.size() > 0 && $urandom_range(99) < p_resp) presenting = 1'b1;
    alu_resp_valid_i  = presenting;
    alu_resp_result_i = presenting ? alu_q[0] : rand_wide();
    nar_resp_ready_i  = ($urandom_range(99) < p_prr);
    wide_resp_ready_i = ($urandom_range(99) < p_prr);
  endtask

  task automatic check_and_step();
    bit full, empty, gw, ev, hs, head_n, e_ardy, e_nv, e_wv, pop;
    logic [WW-1:0] r, e_o1, e_o2;
    if (rst_i) begin
      chk("rst_alu_req_valid", WW'(alu_req_valid_o), '0);
      chk("rst_nar_req_ready", WW'(nar_req_ready_o), '0);
      chk("rst_wide_req_ready", WW'(wide_req_ready_o), '0);
      chk("rst_nar_resp_valid", WW'(nar_resp_valid_o), '0);
      chk("rst_wide_resp_valid", WW'(wide_resp_valid_o), '0);
      chk("rst_alu_resp_ready", WW'(alu_resp_ready_o), '0);
      m_rr_wide = 1'b0; m_lock = 1'b0; m_lock_wide = 1'b0; m_err = 1'b0;
      m_tags.delete(); exp_n_q.delete(); exp_w_q.delete();
      return;
    end
    chk("outstanding", WW'(outstanding_o), WW'(m_tags.size()));
    chk("err_flag", WW'(err_unexpected_resp_o), WW'(m_err));

    full  = (m_tags.size() == MO);
    empty = (m_tags.size() == 0);
    if (m_lock)         gw = m_lock_wide;
    else if (m_rr_wide) gw = wide_req_valid_i;
    else                gw = !nar_req_valid_i;
    ev = !full && (gw ? wide_req_valid_i : nar_req_valid_i);
    chk("alu_req_valid", WW'(alu_req_valid_o), WW'(ev));
    chk("nar_req_ready", WW'(nar_req_ready_o), WW'(!full && !gw && alu_req_ready_i));
    chk("wide_req_ready", WW'(wide_req_ready_o), WW'(!full && gw && alu_req_ready_i));
    e_o1 = gw ? w_a : WW'(n_a);
    e_o2 = gw ? w_b : WW'(n_b);
    if (ev) begin
      chk("alu_is_narrow", WW'(alu_req_is_narrow_o), WW'(!gw));
      chk("alu_op", WW'(alu_req_op_o), WW'(gw ? w_op : n_op));
      chk("alu_operand1", alu_req_operand1_o, e_o1);
      chk("alu_operand2", alu_req_operand2_o, e_o2);
    end
    hs = ev && alu_req_ready_i;

    head_n = empty ? 1'b0 : m_tags[0];
    if (empty) begin
      e_ardy = 1'b1; e_nv = 1'b0; e_wv = 1'b0;
    end else begin
      e_ardy = head_n ? nar_resp_ready_i : wide_resp_ready_i;
      e_nv   = head_n && alu_resp_valid_i;
      e_wv   = !head_n && alu_resp_valid_i;
    end
    chk("alu_resp_ready", WW'(alu_resp_ready_o), WW'(e_ardy));
    chk("nar_resp_valid", WW'(nar_resp_valid_o), WW'(e_nv));
    chk("wide_resp_valid", WW'(wide_resp_valid_o), WW'(e_wv));
    pop = alu_resp_valid_i && e_ardy && !empty;
    if (pop && head_n) begin
      if (exp_n_q.size() == 0) chk("nar_scoreboard_empty", '0, '1);
      else chk("nar_resp_result", WW'(nar_resp_result_o), exp_n_q.pop_front());
    end
    if (pop && !head_n) begin
      if (exp_w_q.size() == 0) chk("wide_scoreboard_empty", '0, '1);
      else chk("wide_resp_result", wide_resp_result_o, exp_w_q.pop_front());
    end

    // Model next state
    if (alu_resp_valid_i && empty) m_err = 1'b1;
    if (pop) void'(m_tags.pop_front());
    if (hs) begin
      m_tags.push_back(!gw);
      if (gw) exp_w_q.push_back(alu_fn(w_op, w_a, w_b));
      else begin
        r = alu_fn(n_op, WW'(n_a), WW'(n_b));
        exp_n_q.push_back(WW'(r[NW-1:0]));
      end
      m_rr_wide = !gw;
      m_lock    = 1'b0;
    end else if (ev) begin
      m_lock      = 1'b1;
      m_lock_wide = gw;
    end

    // Environment reacts to what the DUT actually did
    if (nar_req_valid_i && nar_req_ready_o) n_pend = 1'b0;
    if (wide_req_valid_i && wide_req_ready_o) w_pend = 1'b0;
    if (alu_req_valid_o && alu_req_ready_i)
      alu_q.push_back(alu_fn(alu_req_op_o, alu_req_operand1_o, alu_req_operand2_o));
    if (alu_resp_valid_i && alu_resp_ready_o) begin
      if (alu_q.size() > 0) void'(alu_q.pop_front());
      presenting = 1'b0;
    end
  endtask

  task automatic cycle();
    @(negedge clk_i);
    drive();
    #1;
    check_and_step();
  endtask

  initial begin
    int k;
    n_vec = 0; n_err = 0;
    n_pend = 0; w_pend = 0; presenting = 0; hold_reqs = 0;
    n_op = '0; w_op = '0; n_a = '0; n_b = '0; w_a = '0; w_b = '0;
    rst_i = 1'b1; rst_req = 1'b1;
    nar_req_valid_i = 0; wide_req_valid_i = 0; alu_req_ready_i = 0; alu_resp_valid_i = 0;
    nar_resp_ready_i = 0; wide_resp_ready_i = 0; alu_resp_result_i = '0;
    nar_req_op_i = '0; nar_req_operand1_i = '0; nar_req_operand2_i = '0;
    wide_req_op_i = '0; wide_req_operand1_i = '0; wide_req_operand2_i = '0;
    set_probs(0, 0, 0, 0);
    repeat (3) cycle();
    rst_req = 1'b0;

    set_probs(100, 100, 100, 100); repeat (100) cycle();  // steady alternation
    set_probs(80, 80, 70, 80);     repeat (400) cycle();
    set_probs(90, 90, 3, 90);      repeat (200) cycle();  // responses starve: FIFO fills
    set_probs(80, 25, 60, 80);     repeat (300) cycle();  // ALU stalls exercise the lock
    set_probs(70, 80, 80, 25);     repeat (300) cycle();  // sinks backpressure responses

    // Reset while requests are in flight; their responses must then be dropped.
    set_probs(90, 90, 0, 90);
    k = 0;
    while (alu_q.size() < 2 && k < 200) begin cycle(); k++; end
    chk("inflight_setup", WW'(alu_q.size() >= 2), WW'(1));
    rst_req = 1'b1; hold_reqs = 1'b1; n_pend = 1'b0; w_pend = 1'b0;
    repeat (2) cycle();
    rst_req = 1'b0;
    set_probs(0, 100, 100, 0);
    k = 0;
    while (alu_q.size() > 0 && k < 100) begin cycle(); k++; end
    chk("stale_drain", WW'(alu_q.size()), '0);
    repeat (5) cycle();
    chk("err_sticky", WW'(err_unexpected_resp_o), WW'(1));
    rst_req = 1'b1;
    repeat (2) cycle();
    rst_req = 1'b0; hold_reqs = 1'b0;
    set_probs(80, 70, 70, 70); repeat (300) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
